modulo_controle_ataque: RTL

MODULO_CONTROLE_ATAQUE -- requirements
Module: modulo_controle_ataque

---
 rtl/modulo_controle_ataque_pkg.sv | 43 ++++
 rtl/modulo_detector_borda.sv | 27 ++
 rtl/modulo_controle_ataque.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/modulo_controle_ataque_pkg.sv
// Shared types and helpers for the attack controller of the 7x5 naval battle board.
// Optional feature macro: ATTACK_LIMIT_EN (shot budget enforcement, consumed by the top).
package modulo_controle_ataque_pkg;

    localparam int unsigned ROWS    = 7;
    localparam int unsigned COLS    = 5;
    localparam int unsigned CELLS   = 35;
    localparam int unsigned CNT_W   = 6;
    localparam int unsigned COORD_W = 6;

    typedef enum logic [1:0] {
        ST_ARM  = 2'd0,
        ST_PLAY = 2'd1,
        ST_EVAL = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        STAT_READY   = 3'd0,
        STAT_WATER   = 3'd1,
        STAT_HIT     = 3'd2,
        STAT_REPEAT  = 3'd3,
        STAT_INVALID = 3'd4,
        STAT_WIN     = 3'd5,
        STAT_LOSE    = 3'd6
    } status_t;

    // Number of ship cells on the board.
    function automatic logic [CNT_W-1:0] popcount_cells(input logic [CELLS-1:0] v);
        logic [CNT_W-1:0] s;
        s = '0;
        for (int i = 0; i < CELLS; i++) begin
            s = s + CNT_W'(v[i]);
        end
        return s;
    endfunction

    // Linear bit position of (row, col); only meaningful for in-range coordinates.
    function automatic logic [CNT_W-1:0] cell_index(input logic [2:0] row, input logic [2:0] col);
        return CNT_W'(row) * CNT_W'(COLS) + CNT_W'(col);
    endfunction

endpackage

// File: rtl/modulo_detector_borda.sv
// Rising-edge detector for the already-synchronized confirm level; one pulse per press.
module modulo_detector_borda
    import modulo_controle_ataque_pkg::*;
(
    input  logic clk,
    input  logic clr,
    input  logic i_level,
    output logic o_edge
);

    logic r_prev;
    logic r_edge;

    // Remember last level and register a one-cycle pulse on a 0->1 transition.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_prev <= 1'b0;
            r_edge <= 1'b0;
        end else begin
            r_prev <= i_level;
            r_edge <= i_level & ~r_prev;
        end
    end

    assign o_edge = r_edge;

endmodule

// File: rtl/modulo_controle_ataque.sv
// Attack controller: accepts confirmed shots, tracks attacked cells and decides win/lose.
// Optional feature macro: ATTACK_LIMIT_EN -- when defined, MAX_SHOTS valid shots end the game.
module modulo_controle_ataque
    import modulo_controle_ataque_pkg::*;
#(
    parameter int unsigned MAX_SHOTS = 20
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             confirm,
    input  logic [5:0]       coord,
    input  logic [CELLS-1:0] m_po,
    output logic [CELLS-1:0] m_at,
    output logic [2:0]       status,
    output logic [5:0]       hits_left,
    output logic [5:0]       shots_used,
    output logic             busy
);

`ifdef ATTACK_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif
    // Without a limit the budget sits above the saturation point, so LOSE never fires.
    localparam int unsigned BUDGET = LIMIT_EN ? MAX_SHOTS : CELLS + 1;

    state_t             r_state;
    status_t            r_status;
    status_t            r_end_status;
    logic [CELLS-1:0]   r_m_at;
    logic [CNT_W-1:0]   r_hits;
    logic [CNT_W-1:0]   r_shots;
    logic [COORD_W-1:0] r_coord;
    logic               r_busy;

    logic               w_edge;
    logic [CNT_W-1:0]   w_pop;
    logic [2:0]         w_row;
    logic [2:0]         w_col;
    logic               w_valid;
    logic [CELLS-1:0]   w_mask;
    logic               w_already;
    logic               w_ship;
    status_t            w_shot_status;
    logic [CELLS-1:0]   w_m_at_next;
    logic [CNT_W-1:0]   w_hits_next;
    logic [CNT_W-1:0]   w_shots_next;
    logic               w_win;
    logic               w_lose;

    modulo_detector_borda u_borda (
        .clk     (clk),
        .clr     (clr),
        .i_level (confirm),
        .o_edge  (w_edge)
    );

    assign w_pop = popcount_cells(m_po);
    assign w_row = r_coord[5:3];
    assign w_col = r_coord[2:0];

    // Shot evaluation on the latched coordinate.
    always_comb begin
        w_valid       = (w_row <= 3'(ROWS - 1)) && (w_col <= 3'(COLS - 1));
        w_mask        = w_valid ? (CELLS'(1) << cell_index(w_row, w_col)) : '0;
        w_already     = |(r_m_at & w_mask);
        w_ship        = |(m_po & w_mask);
        w_shot_status = STAT_WATER;
        w_m_at_next   = r_m_at;
        w_hits_next   = r_hits;
        w_shots_next  = r_shots;
        if (!w_valid) begin
            w_shot_status = STAT_INVALID;
        end else if (w_already) begin
            w_shot_status = STAT_REPEAT;
        end else begin
            w_m_at_next  = r_m_at | w_mask;
            w_shots_next = (r_shots < CNT_W'(CELLS)) ? r_shots + CNT_W'(1) : r_shots;
            if (w_ship) begin
                w_shot_status = STAT_HIT;
                w_hits_next   = (r_hits != '0) ? r_hits - CNT_W'(1) : r_hits;
            end
        end
        w_win  = (w_hits_next == '0);
        w_lose = (w_shots_next >= CNT_W'(BUDGET));
    end

    // Game FSM with registered outputs; clr wins over any pending edge or evaluation.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state      <= ST_ARM;
            r_status     <= STAT_READY;
            r_end_status <= STAT_READY;
            r_m_at       <= '0;
            r_hits       <= '0;
            r_shots      <= '0;
            r_coord      <= '0;
            r_busy       <= 1'b1;
        end else begin
            case (r_state)
                ST_ARM: begin
                    r_hits   <= w_pop;
                    r_status <= STAT_READY;
                    if (w_pop != '0) begin
                        r_state <= ST_PLAY;
                        r_busy  <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (w_edge) begin
                        r_coord <= coord;
                        r_state <= ST_EVAL;
                        r_busy  <= 1'b1;
                    end
                end
                ST_EVAL: begin
                    r_m_at   <= w_m_at_next;
                    r_hits   <= w_hits_next;
                    r_shots  <= w_shots_next;
                    r_status <= w_shot_status;
                    if (w_win) begin
                        r_state      <= ST_OVER;
                        r_end_status <= STAT_WIN;
                    end else if (w_lose) begin
                        r_state      <= ST_OVER;
                        r_end_status <= STAT_LOSE;
                    end else begin
                        r_state <= ST_PLAY;
                        r_busy  <= 1'b0;
                    end
                end
                ST_OVER: begin
                    // Shot result is shown for one cycle, then the final verdict is held.
                    r_status <= r_end_status;
                end
                default: begin
                    r_state <= ST_ARM;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign m_at       = r_m_at;
    assign status     = r_status;
    assign hits_left  = r_hits;
    assign shots_used = r_shots;
    assign busy       = r_busy;

endmodule
